// File: rtl/garegga_pixmix.sv
// Final pixel compositor: priority select, palette fetch, xBGR555->RGB888, blank alignment.
// Optional build macro PIXMIX_LAYERMASK_EN adds LAYER_MASK[1:0] per-layer enables.
module garegga_pixmix #(
  parameter int unsigned PAL_LAT  = 1,
  parameter logic [3:0]  PRIO_TOP = 4'hF
) (
  input  logic        CLK96,
  input  logic        RESET96_N,
  input  logic        PIXEL_CEN,
  input  logic        HB,
  input  logic        VB,
  input  logic [10:0] EXTRATEXT_PIXEL,
  input  logic [10:0] GP_PIXEL,
  input  logic [3:0]  GP_PRIO,
`ifdef PIXMIX_LAYERMASK_EN
  input  logic [1:0]  LAYER_MASK,
`endif
  output logic [10:0] PAL_ADDR,
  input  logic [15:0] PAL_DATA,
  output logic [7:0]  RED,
  output logic [7:0]  GREEN,
  output logic [7:0]  BLUE,
  output logic        LHBL,
  output logic        LVBL
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CAPTURE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [14:0]      hold;
  logic             hb_d, vb_d;
  logic             capture_c;
  logic             text_op_c, gp_op_c;
  logic [10:0]      sel_c;
  logic             pal_unused_c;

  assign pal_unused_c = PAL_DATA[15];

  function automatic logic [7:0] exp5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  // Layer transparency and priority select
  always_comb begin
`ifdef PIXMIX_LAYERMASK_EN
    text_op_c = (|EXTRATEXT_PIXEL[3:0]) & LAYER_MASK[0];
    gp_op_c   = (|GP_PIXEL[3:0]) & LAYER_MASK[1];
`else
    text_op_c = |EXTRATEXT_PIXEL[3:0];
    gp_op_c   = |GP_PIXEL[3:0];
`endif
    sel_c = 11'h000;
    if (gp_op_c && (GP_PRIO == PRIO_TOP)) sel_c = GP_PIXEL;
    else if (text_op_c)                   sel_c = EXTRATEXT_PIXEL;
    else if (gp_op_c)                     sel_c = GP_PIXEL;
  end

  // Fetch FSM state register
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Fetch FSM next state; a new strobe always restarts the fetch
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (PIXEL_CEN) begin
      state_nxt = ST_WAIT;
      cnt_nxt   = CNT_W'(PAL_LAT);
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            state_nxt = ST_CAPTURE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        ST_CAPTURE: state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Fetch FSM outputs
  always_comb begin
    capture_c = 1'b0;
    if (state == ST_CAPTURE && !PIXEL_CEN) capture_c = 1'b1;
  end

  // Palette holding register
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) hold <= '0;
    else if (capture_c) hold <= PAL_DATA[14:0];
  end

  // Pixel-rate pipeline: address/blank stage 1, colour/blank stage 2
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      PAL_ADDR <= '0;
      hb_d     <= 1'b1;
      vb_d     <= 1'b1;
      RED      <= '0;
      GREEN    <= '0;
      BLUE     <= '0;
      LHBL     <= 1'b0;
      LVBL     <= 1'b0;
    end else if (PIXEL_CEN) begin
      PAL_ADDR <= sel_c;
      hb_d     <= HB;
      vb_d     <= VB;
      LHBL     <= ~hb_d;
      LVBL     <= ~vb_d;
      if (hb_d || vb_d) begin
        RED   <= '0;
        GREEN <= '0;
        BLUE  <= '0;
      end else begin
        RED   <= exp5(hold[4:0]);
        GREEN <= exp5(hold[9:5]);
        BLUE  <= exp5(hold[14:10]);
      end
    end
  end

endmodule

// File: doc/garegga_pixmix.md
# garegga_pixmix

Final pixel compositor for the Garegga-family video path, downstream of the extra-text line renderer and the GP9001 layer output. Each pixel it selects one 11-bit palette index from the extra-text and GP9001 pixels by transparency and priority, fetches that colour from palette RAM, expands xBGR555 to RGB888 and drives registered colour plus delayed blanking to the video output.

## Interface
Parameters:
- PAL_LAT, 1, palette RAM read latency in CLK96 cycles (1 or 2).
- PRIO_TOP, 4'hF, GP9001 priority value that is drawn above extra text.

Ports:
- CLK96  in  1  pixel-domain clock, all logic on its rising edge.
- RESET96_N  in  1  asynchronous, active-low reset.
- PIXEL_CEN  in  1  one-CLK96 pixel strobe; period ≥ PAL_LAT+3 CLK96.
- HB  in  1  horizontal blank, sampled on PIXEL_CEN.
- VB  in  1  vertical blank, sampled on PIXEL_CEN.
- EXTRATEXT_PIXEL  in  11  extra-text palette index; [3:0]==0 means transparent.
- GP_PIXEL  in  11  GP9001 palette index; [3:0]==0 means transparent.
- GP_PRIO  in  4  GP9001 pixel priority.
- PAL_ADDR  out  11  palette RAM read address.
- PAL_DATA  in  16  palette word, {x, B[4:0], G[4:0], R[4:0]}.
- RED, GREEN, BLUE  out  8 each  output colour.
- LHBL  out  1  active-low H blank, aligned with colour.
- LVBL  out  1  active-low V blank, aligned with colour.

## Operation
- Select, on PIXEL_CEN: GP opaque and GP_PRIO==PRIO_TOP → GP_PIXEL; else text opaque → EXTRATEXT_PIXEL; else GP opaque → GP_PIXEL; else 11'h000 (backdrop, palette entry 0).
- Selected index is registered onto PAL_ADDR on the same PIXEL_CEN edge; HB/VB registered into stage-1 blank flags.
- Fetch FSM: IDLE → (PIXEL_CEN) WAIT, counter loaded with PAL_LAT → decrements per CLK96 → CAPTURE when counter hits 0: latch PAL_DATA into colour holding register → IDLE.
- Expansion: R8 = {R5, R5[4:2]}, same for G and B; bit 15 ignored.
- On next PIXEL_CEN, holding register and stage-1 blank flags transfer to RED/GREEN/BLUE and LHBL=~HB_d, LVBL=~VB_d. When HB_d|VB_d, colour outputs forced to 0.
- PIXEL_CEN arriving while FSM not IDLE (cadence violation): outputs take the previous holding value, FSM restarts on new address; no lock-up.
- Reset: PAL_ADDR=0, RED/GREEN/BLUE=0, LHBL=0, LVBL=0, FSM IDLE, holding register 0. Reset mid-fetch aborts the fetch; first valid pixel appears two PIXEL_CEN strobes after release.

## Timing
- Pixel latency: input sampled at strobe N, colour visible after strobe N+1 (2-strobe pipeline); LHBL/LVBL share that latency exactly.
- PAL_ADDR valid 1 CLK96 after strobe N and held until strobe N+1.
- PAL_DATA captured PAL_LAT CLK96 after PAL_ADDR changes.
- Outputs change only on CLK96 edges where PIXEL_CEN=1; stable otherwise.
- Simultaneous text and GP opaque with equal transparency: priority rule above is the only tie-break; no blending.

## Configuration
- PIXMIX_LAYERMASK_EN defined: adds input LAYER_MASK[1:0] (bit0 text, bit1 GP); a cleared bit forces that layer transparent before selection, sampled on PIXEL_CEN.
- Not defined: no LAYER_MASK port; both layers always enabled.

## Test plan
- Text 11'h805, GP 11'h123 prio 2, pal[805]=16'h7FFF → RGB FF/FF/FF two strobes later, PAL_ADDR=805.
- Text 11'h805, GP 11'h123 prio F, pal[123]=16'h001F → R=FF,G=00,B=00.
- Both indices low nibble 0, pal[000]=16'h03E0 → R=00,G=FF,B=00 (backdrop).
- HB=1 at strobe N with opaque text → at N+1 LHBL=0, RGB=0; HB drop → LHBL=1 aligned with first colour.
- Assert RESET96_N=0 mid-WAIT → all outputs 0 immediately; after release, first colour at second strobe; PAL_LAT=1 and 2 both checked.
- With PIXMIX_LAYERMASK_EN, LAYER_MASK=2'b10, text opaque 805, GP 123 prio 2 → pal[123] output; LAYER_MASK=0 → backdrop.
